// File: rtl/difftest_step_scheduler_pkg.sv
// difftest_sched_pkg: scheduler state encoding and host result codes
package difftest_sched_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_e;
  localparam logic [7:0] SIMV_CONT = 8'd0;
  localparam logic [7:0] SIMV_DONE = 8'd1;
  localparam logic [7:0] SIMV_FAIL = 8'd2;
endpackage

// File: rtl/difftest_step_scheduler_rr_pick.sv
// rr_pick: first set request at or after the pointer, wrapping around
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_o,
  output logic          hit_o
);
  always_comb begin
    gnt_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) gnt_o = IW'((int'(ptr_i) + k) % N);
  end
  assign hit_o = |req_i;
endmodule

// File: rtl/difftest_step_scheduler.sv
// difftest_step_scheduler: batches per-core commit steps onto one host
// step/result channel, round-robin, and keeps the sticky simulation result.
module difftest_step_scheduler
  import difftest_sched_pkg::*;
#(
  parameter int NCORE = 2,
  parameter int STEPW = 8,
  parameter int ACCW  = 12,
  parameter int MAXB  = 64,
  localparam int CW   = NCORE > 1 ? $clog2(NCORE) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NCORE*STEPW-1:0] core_step,
  output logic [NCORE-1:0]       core_stall,
  output logic                   req_valid,
  output logic [CW-1:0]          req_core,
  output logic [ACCW-1:0]        req_step,
  input  logic                   req_ready,
  input  logic                   rsp_valid,
  input  logic [7:0]             rsp_result,
  input  logic                   result_clear,
  output logic [7:0]             simv_result,
  output logic                   perf_dump,
  output logic                   busy
);
  localparam logic [ACCW-1:0] ACC_MAX  = '1;
  localparam logic [ACCW-1:0] STALL_TH = ACC_MAX - ACCW'((1 << STEPW) - 1);
  localparam logic [ACCW-1:0] MAXB_W   = ACCW'(MAXB);

  state_e            state_q;
  logic [ACCW-1:0]   acc_q [NCORE];
  logic [ACCW-1:0]   acc_d [NCORE];
  logic [ACCW:0]     sum [NCORE];
  logic [NCORE-1:0]  nz, sat;
  logic [CW-1:0]     rr_q, gnt, req_core_q;
  logic [ACCW-1:0]   req_step_q;
  logic [7:0]        simv_q;
  logic              req_valid_q, hit, hs, clr, ovf_q;

  assign hs = state_q == REQ && req_ready;
  assign clr = state_q == HALT && result_clear;

  // The grant is subtracted before the add, so the intermediate never underflows.
  always_comb begin
    for (int i = 0; i < NCORE; i++) begin
      sum[i] = {1'b0, acc_q[i] - ((hs && req_core_q == CW'(i)) ? req_step_q : '0)}
             + (ACCW+1)'(core_step[i*STEPW +: STEPW]);
      sat[i] = sum[i][ACCW];
      acc_d[i] = sat[i] ? ACC_MAX : sum[i][ACCW-1:0];
      nz[i] = acc_q[i] != '0;
      core_stall[i] = acc_q[i] >= STALL_TH;
    end
  end

  rr_pick #(.N(NCORE), .IW(CW)) u_pick (
    .req_i (nz),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .hit_o (hit)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      req_valid_q <= 1'b0;
      req_core_q  <= '0;
      req_step_q  <= '0;
      simv_q      <= SIMV_CONT;
      ovf_q       <= 1'b0;
      for (int i = 0; i < NCORE; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCORE; i++) acc_q[i] <= clr ? '0 : acc_d[i];
      ovf_q <= ovf_q | (|sat);
      case (state_q)
        IDLE: if (hit) begin
          req_core_q  <= gnt;
          req_step_q  <= acc_q[gnt] > MAXB_W ? MAXB_W : acc_q[gnt];
          req_valid_q <= 1'b1;
          state_q     <= REQ;
        end
        REQ: if (req_ready) begin
          rr_q        <= req_core_q == CW'(NCORE - 1) ? '0 : req_core_q + 1'b1;
          req_valid_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: if (rsp_valid) begin
          simv_q  <= rsp_result == SIMV_CONT ? SIMV_CONT :
                     rsp_result == SIMV_DONE ? SIMV_DONE : SIMV_FAIL;
          state_q <= rsp_result == SIMV_CONT ? IDLE : HALT;
        end
        default: if (result_clear) begin
          simv_q  <= SIMV_CONT;
          rr_q    <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!ovf_q) else $error("step accumulator overflow");
      assert (!(rsp_valid && (state_q == IDLE || state_q == REQ)))
        else $error("rsp_valid with no request outstanding");
    end
  end

  assign req_valid   = req_valid_q;
  assign req_core    = req_core_q;
  assign req_step    = req_step_q;
  assign simv_result = simv_q;
  assign perf_dump   = simv_q != SIMV_CONT;
  assign busy        = state_q != IDLE || |nz;
endmodule
